// File: rtl/instr_decode_stage.sv
// instr_decode_stage
//
// Registered instruction-decode stage sitting between fetch and the register
// file / ALU. Each accepted instruction is split into its R/I/J fields, fields
// that do not belong to the decoded format are forced to zero, the immediate is
// extended and the jump target is formed. The decoded bundle is written into a
// DEPTH-entry FIFO, so fetch back-pressure and pipeline flush are absorbed here.
//
// Parameters
//   XLEN        datapath width of out_imm / in_pc / out_jtarget / out_pc (>= 32)
//   REG_AW      register-address width (>= 5); MSBs above bit 4 are always zero
//   DEPTH       FIFO entries (power of 2, >= 2)
//   ZEXT_LOGIC  1: andi/ori/xori zero-extend their immediate; 0: everything sign-extends
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous drop of all held and incoming instructions
//   in_valid/in_ready   fetch-side handshake; in_ready depends on held state only
//   in_instr, in_pc     raw instruction and its address
//   out_valid/out_ready consumer-side handshake
//   out_fmt             0=R, 1=I, 2=J
//   out_op .. out_pc    decoded head-of-FIFO bundle, all zero while empty
//   occupancy           number of bundles held

module instr_decode_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 2,
  parameter bit          ZEXT_LOGIC = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,

  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,

  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_fmt,
  output logic [5:0]               out_op,
  output logic [REG_AW-1:0]        out_rs1,
  output logic [REG_AW-1:0]        out_rs2,
  output logic [REG_AW-1:0]        out_ws,
  output logic [4:0]               out_shamt,
  output logic [5:0]               out_funct,
  output logic [XLEN-1:0]          out_imm,
  output logic [XLEN-1:0]          out_jtarget,
  output logic [XLEN-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  localparam logic [OccW-1:0] OccFull = OccW'(DEPTH);
  localparam logic [OccW-1:0] OccOne  = OccW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  localparam logic [1:0] FmtR = 2'd0;
  localparam logic [1:0] FmtI = 2'd1;
  localparam logic [1:0] FmtJ = 2'd2;

  typedef struct packed {
    logic [1:0]        fmt;
    logic [5:0]        op;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] ws;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   jtarget;
    logic [XLEN-1:0]   pc;
  } bundle_t;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [5:0] op;
  logic       logic_imm;
  logic [1:0] fmt;
  bundle_t    dec;

  assign op        = in_instr[31:26];
  assign logic_imm = (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001110);

  always_comb begin
    case (op)
      6'b000000, 6'b010000: fmt = FmtR;
      6'b000010, 6'b010011: fmt = FmtJ;
      default:              fmt = FmtI;
    endcase
  end

  always_comb begin
    // Start from all-zero so fields outside the format never carry instruction bits.
    dec     = '0;
    dec.fmt = fmt;
    dec.op  = op;
    dec.pc  = in_pc;

    if (fmt != FmtJ) begin
      dec.rs1[4:0] = in_instr[25:21];
      dec.rs2[4:0] = in_instr[20:16];
    end

    if (fmt == FmtR) begin
      dec.ws[4:0] = in_instr[15:11];
      dec.shamt   = in_instr[10:6];
      dec.funct   = in_instr[5:0];
    end

    if (fmt == FmtI) begin
      dec.imm[15:0] = in_instr[15:0];
      if (!(ZEXT_LOGIC && logic_imm)) begin
        dec.imm[XLEN-1:16] = {(XLEN-16){in_instr[15]}};
      end
    end

    if (fmt == FmtJ) begin
      dec.jtarget = {in_pc[XLEN-1:28], in_instr[25:0], 2'b00};
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  bundle_t         mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic            push, pop;

  // in_ready is a pure function of held state: no path from out_ready.
  assign in_ready  = (occ_q < OccFull);
  assign out_valid = (occ_q != '0);

  // A flush cycle discards the incoming instruction and ignores out_ready.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;

      case ({push, pop})
        2'b10:   occ_d = occ_q + OccOne;
        2'b01:   occ_d = occ_q - OccOne;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= dec;
    end
  end

  // ---------------------------------------------------------------------------
  // Output bundle: head entry, forced to zero while empty
  // ---------------------------------------------------------------------------
  bundle_t head;

  always_comb begin
    head = '0;
    if (out_valid) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign out_fmt     = head.fmt;
  assign out_op      = head.op;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_ws      = head.ws;
  assign out_shamt   = head.shamt;
  assign out_funct   = head.funct;
  assign out_imm     = head.imm;
  assign out_jtarget = head.jtarget;
  assign out_pc      = head.pc;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage. Stimulus pushes the hand-decoded
// expected bundle when an instruction is handed over; a negedge monitor checks
// the head bundle every cycle and pops on a completed output handshake.
// A second instance with ZEXT_LOGIC=0 shares all inputs and supplies imm_s.

module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;

  logic        in_ready, out_valid;
  logic [1:0]  out_fmt;
  logic [5:0]  out_op, out_funct;
  logic [4:0]  out_rs1, out_rs2, out_ws, out_shamt;
  logic [31:0] out_imm, out_jtarget, out_pc;
  logic [1:0]  occupancy;

  logic        s_in_ready, s_out_valid;
  logic [1:0]  s_out_fmt;
  logic [5:0]  s_out_op, s_out_funct;
  logic [4:0]  s_out_rs1, s_out_rs2, s_out_ws, s_out_shamt;
  logic [31:0] s_out_imm, s_out_jtarget, s_out_pc;
  logic [1:0]  s_occupancy;

  instr_decode_stage #(
    .XLEN(32), .REG_AW(5), .DEPTH(2), .ZEXT_LOGIC(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_fmt(out_fmt), .out_op(out_op),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_ws(out_ws), .out_shamt(out_shamt),
    .out_funct(out_funct), .out_imm(out_imm), .out_jtarget(out_jtarget), .out_pc(out_pc),
    .occupancy(occupancy)
  );

  instr_decode_stage #(
    .XLEN(32), .REG_AW(5), .DEPTH(2), .ZEXT_LOGIC(1'b0)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_fmt(s_out_fmt), .out_op(s_out_op),
    .out_rs1(s_out_rs1), .out_rs2(s_out_rs2), .out_ws(s_out_ws), .out_shamt(s_out_shamt),
    .out_funct(s_out_funct), .out_imm(s_out_imm), .out_jtarget(s_out_jtarget),
    .out_pc(s_out_pc), .occupancy(s_occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  ws;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm;
    logic [31:0] imm_s;
    logic [31:0] jt;
    logic [31:0] pc;
  } exp_t;

  exp_t        vec_e [9];
  logic [31:0] vec_i [9];
  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare head against scoreboard every cycle; pop on a real handshake.
  always @(negedge clk) begin
    exp_t act;
    act = '{fmt: out_fmt, op: out_op, rs1: out_rs1, rs2: out_rs2, ws: out_ws,
            shamt: out_shamt, funct: out_funct, imm: out_imm, imm_s: s_out_imm,
            jt: out_jtarget, pc: out_pc};
    if (!out_valid) begin
      chk("idle_zero", 192'(act), 192'(0));
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_bundle: got=%0h expected=none at %0t", act, $time);
    end else begin
      chk("bundle", 192'(act), 192'(sb[0]));
      if (out_ready && !flush) void'(sb.pop_front());
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int k);
    int n = 0;
    in_valid = 1'b1;
    in_instr = vec_i[k];
    in_pc    = vec_e[k].pc;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected=1 for vector %0d", k);
    end else begin
      sb.push_back(vec_e[k]);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (occupancy != 2'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_occ", 192'(occupancy), 192'(0));
    chk("drain_sb", 192'(sb.size()), 192'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    //            fmt op     rs1 rs2 ws sh funct imm           imm_s         jt            pc
    vec_i[0] = 32'h012A4020;
    vec_e[0] = '{2'd0, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 32'h0, 32'h0, 32'h0, 32'h100};
    vec_i[1] = 32'h2128FFFF;
    vec_e[1] = '{2'd1, 6'h08, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'h0, 32'h104};
    vec_i[2] = 32'h3528FFFF;
    vec_e[2] = '{2'd1, 6'h0D, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 32'h0000FFFF, 32'hFFFFFFFF,
                 32'h0, 32'h108};
    vec_i[3] = 32'h08000040;
    vec_e[3] = '{2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 32'h0, 32'h40000100,
                 32'h40000010};
    vec_i[4] = 32'h40851183;
    vec_e[4] = '{2'd0, 6'h10, 5'd4, 5'd5, 5'd2, 5'd6, 6'h03, 32'h0, 32'h0, 32'h0, 32'h200};
    vec_i[5] = 32'h4C000003;
    vec_e[5] = '{2'd2, 6'h13, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 32'h0, 32'h8000000C,
                 32'h80000000};
    vec_i[6] = 32'h30008001;
    vec_e[6] = '{2'd1, 6'h0C, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h00008001, 32'hFFFF8001,
                 32'h0, 32'h20C};
    vec_i[7] = 32'h3C008000;
    vec_e[7] = '{2'd1, 6'h0F, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'hFFFF8000, 32'hFFFF8000,
                 32'h0, 32'h210};
    vec_i[8] = 32'h38001234;
    vec_e[8] = '{2'd1, 6'h0E, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h00001234, 32'h00001234,
                 32'h0, 32'h214};

    // Reset state
    #2;
    chk("rst_out_valid", 192'(out_valid), 192'(0));
    chk("rst_in_ready", 192'(in_ready), 192'(1));
    chk("rst_occ", 192'(occupancy), 192'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single R instruction: visible one edge after accept
    out_ready = 1'b1;
    send(0);
    chk("lat_valid", 192'(out_valid), 192'(1));
    chk("lat_occ", 192'(occupancy), 192'(1));
    drain();

    // All formats back-to-back, including extension boundaries
    for (int k = 1; k < 9; k++) send(k);
    drain();

    // Back-pressure: two held, third held off at the source
    out_ready = 1'b0;
    send(0);
    send(1);
    chk("full_occ", 192'(occupancy), 192'(2));
    chk("full_in_ready", 192'(in_ready), 192'(0));
    fork
      send(2);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("held_in_ready", 192'(in_ready), 192'(0));
          chk("held_occ", 192'(occupancy), 192'(2));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Simultaneous push/pop at occupancy 1 for 8 cycles
    out_ready = 1'b1;
    send(0);
    fork
      begin
        for (int k = 1; k < 9; k++) send(k);
      end
      begin
        repeat (8) begin
          @(negedge clk);
          chk("pp_occ", 192'(occupancy), 192'(1));
        end
      end
    join
    drain();

    // Flush with two held and an incoming instruction; out_ready must be ignored
    out_ready = 1'b0;
    send(0);
    send(1);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = vec_i[2];
    in_pc     = vec_e[2].pc;
    @(negedge clk);
    chk("pre_flush_occ", 192'(occupancy), 192'(2));
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("flush_occ", 192'(occupancy), 192'(0));
    chk("flush_valid", 192'(out_valid), 192'(0));
    chk("flush_in_ready", 192'(in_ready), 192'(1));
    @(negedge clk);
    chk("flush_discard", 192'(occupancy), 192'(0));
    @(posedge clk);
    #1;
    send(3);
    chk("post_flush_valid", 192'(out_valid), 192'(1));
    drain();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(4);
    send(5);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_out_valid", 192'(out_valid), 192'(0));
    chk("arst_in_ready", 192'(in_ready), 192'(1));
    chk("arst_occ", 192'(occupancy), 192'(0));
    chk("arst_pc", 192'(out_pc), 192'(0));
    chk("arst_jtarget", 192'(out_jtarget), 192'(0));
    chk("arst_fmt", 192'(out_fmt), 192'(0));
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(6);
    chk("post_rst_valid", 192'(out_valid), 192'(1));
    drain();
    send(7);
    send(8);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
